// File: rtl/ad7606_emu_if.sv
// Parallel-bus pins of the AD7606 emulator, grouped so the emulator and its
// driver share one bundle; the "slave" side is the emulated converter.
interface ad7606_emu_if;
  logic         i_ad_convstA;
  logic         i_ad_convstB;
  logic         i_ad_reset;
  logic         i_ad_cs;
  logic         i_ad_rd;
  logic [127:0] i_smp_data;
  logic         o_ad_busy;
  logic [15:0]  o_ad_data;
  logic         o_ad_frstdata;
  logic         o_overrun;

  modport master (
    output i_ad_convstA, i_ad_convstB, i_ad_reset, i_ad_cs, i_ad_rd, i_smp_data,
    input  o_ad_busy, o_ad_data, o_ad_frstdata, o_overrun
  );

  modport slave (
    input  i_ad_convstA, i_ad_convstB, i_ad_reset, i_ad_cs, i_ad_rd, i_smp_data,
    output o_ad_busy, o_ad_data, o_ad_frstdata, o_overrun
  );
endinterface

// File: rtl/ad7606_emu.sv
// Cycle-based behavioural emulator of an AD7606 8-channel ADC parallel interface:
// CONVST-triggered busy window, 8 result registers, sequential CS/RD readout.
module ad7606_emu #(
  parameter int unsigned P_CONV_CYCLES = 200,
  parameter int unsigned P_RST_RECOVER = 1,
  parameter int unsigned P_PATTERN     = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ad7606_emu_if.slave ad
);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_RESET} state_t;

  state_t      state, state_next;
  logic [15:0] conv_cnt;
  logic [7:0]  rec_cnt;
  logic        prev_a, prev_b, prev_rd;
  logic        conv_start, rd_strobe;
  logic        load_conv, finish_conv, flag_overrun, clear_dev;
  logic [15:0] result [8];
  logic [2:0]  ptr;
  logic [11:0] frame_cnt;
  logic [15:0] data_q;
  logic        frst_q, overrun_q;

  // Edges compare this cycle's pin sample against the previous one.
  assign conv_start = ad.i_ad_convstA & ad.i_ad_convstB & ~(prev_a & prev_b);
  assign rd_strobe  = ~ad.i_ad_cs & ~ad.i_ad_rd & prev_rd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next   = state;
    load_conv    = 1'b0;
    finish_conv  = 1'b0;
    flag_overrun = 1'b0;
    clear_dev    = 1'b0;
    if (ad.i_ad_reset) begin
      state_next = ST_RESET;
      clear_dev  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (conv_start) begin
            state_next = ST_CONV;
            load_conv  = 1'b1;
          end
        end
        ST_CONV: begin
          if (conv_start) flag_overrun = 1'b1;
          if (conv_cnt == 16'd0) begin
            state_next  = ST_IDLE;
            finish_conv = 1'b1;
          end
        end
        ST_RESET: begin
          clear_dev = 1'b1;
          if (rec_cnt == 8'd0) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // History starts at 1 so a pin already high after reset is not seen as an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_a  <= 1'b1;
      prev_b  <= 1'b1;
      prev_rd <= 1'b1;
    end else begin
      prev_a  <= ad.i_ad_convstA;
      prev_b  <= ad.i_ad_convstB;
      prev_rd <= ad.i_ad_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      conv_cnt <= 16'd0;
      rec_cnt  <= 8'd0;
    end else begin
      if (ad.i_ad_reset)                         rec_cnt <= 8'(P_RST_RECOVER);
      else if (state == ST_RESET && rec_cnt != 8'd0) rec_cnt <= rec_cnt - 8'd1;

      if (load_conv)                                  conv_cnt <= 16'(P_CONV_CYCLES - 1);
      else if (state == ST_CONV && conv_cnt != 16'd0) conv_cnt <= conv_cnt - 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: the result bank is a handful of flops that must read back as zero after
    // either reset, so it is cleared explicitly rather than left to power-up state.
    if (i_rst || clear_dev) begin
      for (int n = 0; n < 8; n++) result[n] <= 16'd0;
      ptr       <= 3'd0;
      frame_cnt <= 12'd0;
      data_q    <= 16'd0;
      frst_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (flag_overrun) overrun_q <= 1'b1;

      if (finish_conv) begin
        for (int n = 0; n < 8; n++)
          result[n] <= (P_PATTERN != 0) ? {frame_cnt, 4'(n)} : ad.i_smp_data[16*n +: 16];
        ptr       <= 3'd0;
        frame_cnt <= frame_cnt + 12'd1;
      end

      // A strobe landing on the busy-fall edge is dropped in favour of the new frame.
      if (ad.i_ad_cs || (rd_strobe && finish_conv)) begin
        data_q <= 16'd0;
        frst_q <= 1'b0;
      end else if (rd_strobe) begin
        data_q <= result[ptr];
        frst_q <= (ptr == 3'd0);
        ptr    <= ptr + 3'd1;
      end
    end
  end

  assign ad.o_ad_busy     = (state == ST_CONV);
  assign ad.o_ad_data     = data_q;
  assign ad.o_ad_frstdata = frst_q;
  assign ad.o_overrun     = overrun_q;

endmodule

// File: tb/tb_ad7606_emu.sv
// Drives a pattern-mode and a sample-mode emulator with the same pins; read
// expectations go into a scoreboard that a negedge monitor drains.
module tb_ad7606_emu;

  typedef struct packed {
    logic [15:0] pat;
    logic [15:0] smp;
    logic        frst;
  } exp_t;

  localparam logic [127:0] SMP1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
  localparam logic [127:0] SMP2 = 128'h0807_0706_0605_0504_0403_0302_0201_0100;

  logic         clk = 1'b0;
  logic         rst;
  logic         convst_a, convst_b, ad_reset, cs, rd;
  logic [127:0] smp;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic rd_hist, strobe_seen;

  always #5 clk = ~clk;

  ad7606_emu_if if_pat ();
  ad7606_emu_if if_smp ();

  assign if_pat.i_ad_convstA = convst_a;
  assign if_pat.i_ad_convstB = convst_b;
  assign if_pat.i_ad_reset   = ad_reset;
  assign if_pat.i_ad_cs      = cs;
  assign if_pat.i_ad_rd      = rd;
  assign if_pat.i_smp_data   = smp;
  assign if_smp.i_ad_convstA = convst_a;
  assign if_smp.i_ad_convstB = convst_b;
  assign if_smp.i_ad_reset   = ad_reset;
  assign if_smp.i_ad_cs      = cs;
  assign if_smp.i_ad_rd      = rd;
  assign if_smp.i_smp_data   = smp;

  ad7606_emu #(.P_CONV_CYCLES(20), .P_RST_RECOVER(1), .P_PATTERN(1)) u_pat (
    .i_clk (clk),
    .i_rst (rst),
    .ad    (if_pat)
  );

  ad7606_emu #(.P_CONV_CYCLES(20), .P_RST_RECOVER(1), .P_PATTERN(0)) u_smp (
    .i_clk (clk),
    .i_rst (rst),
    .ad    (if_smp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] pat, input logic [15:0] smpv, input logic frst);
    exp_t e;
    e.pat  = pat;
    e.smp  = smpv;
    e.frst = frst;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_busy(input string name, input logic exp);
    check({name, "_pat"}, 32'(if_pat.o_ad_busy), 32'(exp));
    check({name, "_smp"}, 32'(if_smp.o_ad_busy), 32'(exp));
  endtask

  task automatic check_idle_out(input string name);
    check({name, "_data_pat"}, 32'(if_pat.o_ad_data), 32'h0);
    check({name, "_frst_pat"}, 32'(if_pat.o_ad_frstdata), 32'h0);
    check({name, "_data_smp"}, 32'(if_smp.o_ad_data), 32'h0);
    check({name, "_frst_smp"}, 32'(if_smp.o_ad_frstdata), 32'h0);
  endtask

  task automatic do_read(input exp_t e);
    sb.push_back(e);
    cs = 1'b0;
    rd = 1'b0;
    tick();
    rd = 1'b1;
    tick();
  endtask

  task automatic conv_pulse();
    convst_a = 1'b0;
    convst_b = 1'b0;
    tick();
    convst_a = 1'b1;
    convst_b = 1'b1;
    tick();
  endtask

  // Full 20-cycle conversion with optional overrun glitch, mid-busy read and busy-fall read.
  task automatic run_conv(input bit glitch, input bit rd_mid, input bit rd_fall, input exp_t mid_exp);
    conv_pulse();
    check_busy("busy_rise", 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_busy((k < 20) ? "busy_hold" : "busy_fall", (k < 20));
      if (glitch && k == 5) begin convst_a = 1'b0; convst_b = 1'b0; end
      if (glitch && k == 6) begin convst_a = 1'b1; convst_b = 1'b1; end
      if (rd_mid && k == 10) begin sb.push_back(mid_exp); cs = 1'b0; rd = 1'b0; end
      if (rd_mid && k == 11) rd = 1'b1;
      if (rd_fall && k == 19) begin sb.push_back(mk(16'h0, 16'h0, 1'b0)); cs = 1'b0; rd = 1'b0; end
    end
    rd = 1'b1;
    tick();
  endtask

  // Bench-side view of the read protocol: a strobe at a posedge is checked on the next negedge.
  always @(posedge clk) begin
    if (rst) begin
      rd_hist     <= 1'b1;
      strobe_seen <= 1'b0;
    end else begin
      rd_hist     <= rd;
      strobe_seen <= !cs && !rd && rd_hist;
    end
  end

  always @(negedge clk) begin
    if (strobe_seen) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got data 0x%0h with no expectation queued", if_pat.o_ad_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data_pat", 32'(if_pat.o_ad_data), 32'(e.pat));
        check("rd_frst_pat", 32'(if_pat.o_ad_frstdata), 32'(e.frst));
        check("rd_data_smp", 32'(if_smp.o_ad_data), 32'(e.smp));
        check("rd_frst_smp", 32'(if_smp.o_ad_frstdata), 32'(e.frst));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    convst_a = 1'b1;
    convst_b = 1'b1;
    ad_reset = 1'b0;
    cs       = 1'b1;
    rd       = 1'b1;
    smp      = SMP1;
    repeat (3) tick();
    check_busy("rst_busy", 1'b0);
    check_idle_out("rst");
    check("rst_ovr_pat", 32'(if_pat.o_overrun), 32'h0);
    check("rst_ovr_smp", 32'(if_smp.o_overrun), 32'h0);
    rst = 1'b0;
    tick();

    // Frame 0: pattern 0x0000..0x0007, samples 0x1111..0x8888.
    run_conv(1'b0, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0));
    check("f0_no_overrun", 32'(if_pat.o_overrun), 32'h0);
    for (int i = 0; i < 8; i++)
      do_read(mk(16'(i), 16'(16'h1111 * (i + 1)), (i == 0)));
    cs = 1'b1;
    tick();
    check_idle_out("cs_high");
    for (int i = 0; i < 4; i++) begin
      rd = ~rd;
      tick();
      check("cs_high_rd_toggle_smp", 32'(if_smp.o_ad_data), 32'h0);
      check("cs_high_rd_toggle_pat", 32'(if_pat.o_ad_data), 32'h0);
    end
    rd = 1'b1;
    tick();

    // Frame 1: pointer survives a CS-high pause and wraps after channel 8.
    smp = SMP2;
    run_conv(1'b0, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0));
    for (int i = 0; i < 3; i++)
      do_read(mk(16'(16'h0010 + i), {8'(i + 1), 8'(i)}, (i == 0)));
    cs = 1'b1;
    repeat (2) tick();
    for (int i = 3; i < 8; i++)
      do_read(mk(16'(16'h0010 + i), {8'(i + 1), 8'(i)}, 1'b0));
    do_read(mk(16'h0010, 16'h0100, 1'b1));

    // Frame 2: overrun glitch, read of old frame while busy, read colliding with busy-fall.
    smp = SMP1;
    run_conv(1'b1, 1'b1, 1'b1, mk(16'h0011, 16'h0201, 1'b0));
    check("ovr_set_pat", 32'(if_pat.o_overrun), 32'h1);
    check("ovr_set_smp", 32'(if_smp.o_overrun), 32'h1);
    do_read(mk(16'h0020, 16'h1111, 1'b1));
    do_read(mk(16'h0021, 16'h2222, 1'b0));
    check("ovr_sticky", 32'(if_pat.o_overrun), 32'h1);
    ad_reset = 1'b1;
    tick();
    ad_reset = 1'b0;
    repeat (2) tick();
    check("ovr_cleared_pat", 32'(if_pat.o_overrun), 32'h0);
    check("ovr_cleared_smp", 32'(if_smp.o_overrun), 32'h0);

    // Device reset mid-conversion, start during recovery ignored.
    conv_pulse();
    check_busy("dr_busy_start", 1'b1);
    repeat (4) tick();
    ad_reset = 1'b1;
    tick();
    check_busy("dr_busy_abort", 1'b0);
    repeat (2) tick();
    ad_reset = 1'b0;
    convst_a = 1'b0;
    convst_b = 1'b0;
    tick();
    convst_a = 1'b1;
    convst_b = 1'b1;
    tick();
    check_busy("dr_recov_start_ignored", 1'b0);
    tick();
    check_busy("dr_still_idle", 1'b0);
    check("dr_no_overrun", 32'(if_pat.o_overrun), 32'h0);
    do_read(mk(16'h0, 16'h0, 1'b1));
    do_read(mk(16'h0, 16'h0, 1'b0));

    // Device reset again, start one cycle after recovery is accepted.
    ad_reset = 1'b1;
    repeat (3) tick();
    ad_reset = 1'b0;
    convst_a = 1'b0;
    convst_b = 1'b0;
    repeat (2) tick();
    convst_a = 1'b1;
    convst_b = 1'b1;
    tick();
    check_busy("dr_start_after_recov", 1'b1);
    repeat (19) tick();
    check_busy("dr_busy_last", 1'b1);
    tick();
    check_busy("dr_busy_fall", 1'b0);
    for (int i = 0; i < 3; i++)
      do_read(mk(16'(i), 16'(16'h1111 * (i + 1)), (i == 0)));

    // Global reset mid-conversion aborts without loading frame 1 results.
    conv_pulse();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_busy("rst_abort", 1'b0);
    check_idle_out("rst_abort");
    tick();
    do_read(mk(16'h0, 16'h0, 1'b1));
    do_read(mk(16'h0, 16'h0, 1'b0));

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad7606_emu.md
AD7606_EMU -- requirements
Module: ad7606_emu

Interface
REQ-001 Parameters SHALL be:
- P_CONV_CYCLES, default 200: busy duration in clocks; legal range 1..65535.
- P_RST_RECOVER, default 1: clocks after i_ad_reset falls during which CONVST is ignored; legal range 0..255.
- P_PATTERN, default 0: 0 = results taken from i_smp_data; 1 = results from the internal pattern.
REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- i_clk, in, 1: single clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_ad_convstA, in, 1: conversion start A; rising-edge triggered.
- i_ad_convstB, in, 1: conversion start B; rising-edge triggered.
- i_ad_reset, in, 1: device reset, active-high level.
- i_ad_cs, in, 1: chip select, active-low.
- i_ad_rd, in, 1: read strobe, active-low.
- i_smp_data, in, 128: analog sample stand-in; channel n is bits [16n-1:16n-16], n=1..8.
- o_ad_busy, out, 1: conversion in progress.
- o_ad_data, out, 16: parallel read data.
- o_ad_frstdata, out, 1: high while o_ad_data holds channel 1.
- o_overrun, out, 1: sticky error flag, conversion start seen while busy.

Function
REQ-003 All inputs SHALL be sampled on the rising edge of i_clk; edge detection compares the current sample with the previous sample.
REQ-004 The block SHALL use a state machine with three states: ST_IDLE, ST_CONV, ST_RESET.
REQ-005 ST_RESET SHALL be entered from any state whenever i_ad_reset is sampled 1.
REQ-006 In ST_RESET the block SHALL hold o_ad_busy=0, clear all 8 result registers, clear the read pointer, clear the frame counter, set o_ad_data=0, o_ad_frstdata=0 and o_overrun=0.
REQ-007 After i_ad_reset is sampled 0, the block SHALL remain in ST_RESET for P_RST_RECOVER further cycles, then enter ST_IDLE.
REQ-008 A conversion start SHALL be detected when i_ad_convstA and i_ad_convstB are both sampled 1 and at least one of them was 0 in the previous sample.
REQ-009 A conversion start detected in ST_IDLE at clock edge N SHALL set o_ad_busy=1 at edge N and enter ST_CONV.
REQ-010 o_ad_busy SHALL stay high for exactly P_CONV_CYCLES cycles and fall at edge N+P_CONV_CYCLES.
REQ-011 At the edge where busy falls, the block SHALL load all 8 result registers, set the read pointer to 0, increment the 12-bit frame counter (wrapping 4095 to 0) and return to ST_IDLE.
REQ-012 With P_PATTERN=0, result n SHALL equal i_smp_data channel n as sampled at the busy-falling edge.
REQ-013 With P_PATTERN=1, result n SHALL equal {frame_cnt[11:0], 4'(n-1)}, using the frame-counter value before the increment.
REQ-014 A conversion start detected in ST_CONV SHALL be ignored and SHALL set o_overrun=1; o_overrun is sticky until i_rst or i_ad_reset.
REQ-015 A conversion start detected in ST_RESET SHALL be ignored and SHALL NOT set o_overrun.
REQ-016 A read strobe SHALL be detected when i_ad_cs is sampled 0 and i_ad_rd is sampled 0 after previously being 1.
REQ-017 On a read strobe, the block SHALL set o_ad_data to result[ptr], set o_ad_frstdata to (ptr==0), and increment ptr modulo 8 (after channel 8, the next read returns channel 1).
REQ-018 Reads SHALL be serviced in ST_IDLE and ST_CONV; reads during a conversion return the previous results.
REQ-019 While i_ad_cs is sampled 1, o_ad_data and o_ad_frstdata SHALL be 0 and ptr SHALL hold its value; the rising edge of CS does not reset ptr.
REQ-020 When a busy-fall coincides with a read strobe, the busy-fall SHALL win: ptr=0 and o_ad_data=0 that cycle, and the strobe is dropped.

Reset
REQ-021 With i_rst=1 at a clock edge, the block SHALL enter ST_IDLE and set o_ad_busy=0, o_ad_data=0, o_ad_frstdata=0, o_overrun=0, ptr=0, frame_cnt=0, all results=0 and all edge-history registers=1 (no false edge after reset).
REQ-022 i_rst SHALL take priority over every other input.
REQ-023 i_rst or i_ad_reset asserted mid-conversion SHALL abort the conversion without loading results.

Verification
REQ-024 Basic conversion: P_CONV_CYCLES=20, P_PATTERN=1; pulse convstA/B low for 1 cycle, rise sampled at edge N -> busy high on edges N..N+19, low at N+20; 8 reads with CS low return 0x0000..0x0007, with frstdata on the first read only.
REQ-025 Second frame: repeat the conversion -> reads return 0x0010..0x0017; a 9th read without a new conversion returns 0x0010 with frstdata=1.
REQ-026 Overrun: a second CONVST rise during busy -> busy still falls at N+20, o_overrun=1 and stays 1; a subsequent i_ad_reset pulse clears it.
REQ-027 Device reset: i_ad_reset high 3 cycles during busy with P_RST_RECOVER=1 -> busy=0 immediately, reads return 0x0000, a CONVST rise in the recovery cycle is ignored, and a rise one cycle later starts a conversion.
REQ-028 P_PATTERN=0: i_smp_data=0x8888_7777_..._1111 held during the conversion -> reads return 0x1111, 0x2222, ..., 0x8888; with CS high, o_ad_data=0 regardless of RD toggling.
